// File: rtl/dtree_feature_sequencer.sv
// dtree_feature_sequencer
//   Front end for a combinational printed decision-tree classifier.
//   Collects N_FEAT features, one per beat, from a valid/ready stream.
//   Holds the assembled vector on the tree inputs for SETTLE cycles.
//   Then registers the tree class and offers it on a valid/ready result port.
//   Only one vector is in flight at a time.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   s_valid    in   feature beat valid
//   s_ready    out  beat accepted when s_valid & s_ready
//   s_data     in   feature value, X0 first
//   s_last     in   marks the final feature of a vector
//   feat       out  tree inputs, Xi = feat[i*FW +: FW]
//   cls_in     in   combinational class returned by the tree
//   m_valid    out  result valid
//   m_ready    in   result consumed when m_valid & m_ready
//   m_class    out  registered class
//   frame_err  out  one-cycle pulse on a framing error
//   n_results  out  results handed off, wraps at 16 bits
//
// Build option
//   FEATURE_MASK_EN: when defined, the lower FW/2 bits of every feature are
//   stored as zero. The trees only compare the upper bits, so masking the
//   rest reduces toggling on the tree inputs.

module dtree_feature_sequencer #(
    parameter int N_FEAT = 4,
    parameter int FW     = 8,
    parameter int CW     = 2,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [FW-1:0]        s_data,
    input  logic                 s_last,
    output logic [N_FEAT*FW-1:0] feat,
    input  logic [CW-1:0]        cls_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CW-1:0]        m_class,
    output logic                 frame_err,
    output logic [15:0]          n_results
);

    localparam int             IW       = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_FEAT - 1);
    localparam logic [7:0]     CNT_INIT = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic [7:0]            cnt_q;
    logic [N_FEAT*FW-1:0]  feat_q;
    logic                  s_ready_q;
    logic                  m_valid_q;
    logic [CW-1:0]         m_class_q;
    logic                  frame_err_q;
    logic [15:0]           n_results_q;
    logic [FW-1:0]         beat_d;

    // Value actually written into the feature slice for an accepted beat.
    always_comb begin
        beat_d = s_data;
`ifdef FEATURE_MASK_EN
        beat_d[FW/2-1:0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            feat_q      <= '0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            frame_err_q <= 1'b0;
            n_results_q <= '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                // s_ready_q is registered high whenever the state is LOAD,
                // so s_valid alone marks an accepted beat here.
                ST_LOAD: begin
                    if (s_valid) begin
                        feat_q[idx_q*FW +: FW] <= beat_d;
                        if (idx_q == LAST_IDX) begin
                            // Vector complete; a missing s_last is flagged but
                            // the vector is still classified.
                            idx_q       <= '0;
                            cnt_q       <= CNT_INIT;
                            s_ready_q   <= 1'b0;
                            frame_err_q <= !s_last;
                            state_q     <= ST_SETTLE;
                        end else if (s_last) begin
                            // Early s_last: abort the vector and restart at X0.
                            idx_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        m_class_q <= cls_in;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q   <= 1'b0;
                        n_results_q <= n_results_q + 1'b1;
                        s_ready_q   <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign feat      = feat_q;
    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign frame_err = frame_err_q;
    assign n_results = n_results_q;

endmodule

// File: tb/tb_dtree_feature_sequencer.sv
module tb_dtree_feature_sequencer;

    localparam int N_FEAT = 4;
    localparam int FW     = 8;
    localparam int CW     = 2;
    localparam int SETTLE = 2;
`ifdef FEATURE_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [FW-1:0]        s_data = '0;
    logic                 s_last = 1'b0;
    logic [N_FEAT*FW-1:0] feat;
    logic [CW-1:0]        cls_in;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [CW-1:0]        m_class;
    logic                 frame_err;
    logic [15:0]          n_results;

    // Stub tree: class is the low bits of X0.
    assign cls_in = feat[CW-1:0];

    always #5 clk = ~clk;

    dtree_feature_sequencer #(
        .N_FEAT(N_FEAT),
        .FW    (FW),
        .CW    (CW),
        .SETTLE(SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .feat     (feat),
        .cls_in   (cls_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .frame_err(frame_err),
        .n_results(n_results)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Transaction-level reference: beats collected into an array, the result
    // becomes visible at an absolute edge number SETTLE edges after the final
    // beat, and stays until a handshake.
    logic [FW-1:0] m_feat [N_FEAT];
    int            m_pos = 0;
    bit            m_busy = 1'b0;
    bit            m_mv = 1'b0;
    logic [CW-1:0] m_cls = '0;
    bit            m_ferr = 1'b0;
    logic [15:0]   m_nres = '0;
    int            m_done_at = 0;

    function automatic logic [FW-1:0] store_val(input logic [FW-1:0] d);
        logic [FW-1:0] r;
        r = d;
        if (MASK) r[FW/2-1:0] = '0;
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < N_FEAT; i++) m_feat[i] = '0;
            m_pos  = 0;
            m_busy = 1'b0;
            m_mv   = 1'b0;
            m_cls  = '0;
            m_ferr = 1'b0;
            m_nres = '0;
        end else begin
            m_ferr = 1'b0;
            if (!m_busy) begin
                if (s_valid) begin
                    m_feat[m_pos] = store_val(s_data);
                    if (m_pos == N_FEAT - 1) begin
                        m_busy    = 1'b1;
                        m_done_at = cyc + SETTLE;
                        m_ferr    = !s_last;
                        m_pos     = 0;
                    end else if (s_last) begin
                        m_pos  = 0;
                        m_ferr = 1'b1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (!m_mv) begin
                if (cyc == m_done_at) begin
                    m_mv  = 1'b1;
                    m_cls = m_feat[0][CW-1:0];
                end
            end else if (m_ready) begin
                m_mv   = 1'b0;
                m_busy = 1'b0;
                m_nres = m_nres + 16'd1;
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        cmp(name, act, exp);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N_FEAT*FW-1:0] exp_feat;
            for (int i = 0; i < N_FEAT; i++) exp_feat[i*FW +: FW] = m_feat[i];
            vectors++;
            cmp("s_ready",   64'(s_ready),   64'(!m_busy));
            cmp("feat",      64'(feat),      64'(exp_feat));
            cmp("m_valid",   64'(m_valid),   64'(m_mv));
            cmp("m_class",   64'(m_class),   64'(m_cls));
            cmp("frame_err", 64'(frame_err), 64'(m_ferr));
            cmp("n_results", 64'(n_results), 64'(m_nres));
        end
    end

    // Called #1 after an edge; returns the edge number on which the beat was taken.
    task automatic send_beat(input logic [FW-1:0] d, input bit last, output int acc);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL s_ready_timeout: got 0 expected 1 at edge %0d", cyc);
        end
        @(posedge clk); #1;
        acc     = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [FW-1:0] x0, output int acc);
        int a;
        send_beat(x0,    1'b0, a);
        send_beat(8'h00, 1'b0, a);
        send_beat(8'h00, 1'b0, a);
        send_beat(8'h00, 1'b1, acc);
    endtask

    task automatic wait_mvalid(output int e);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        lit("mvalid_seen", 64'(m_valid), 64'd1);
        e = cyc;
    endtask

    initial begin
        int k, e, ok;
        logic [CW-1:0] saved;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        lit("rst_s_ready",   64'(s_ready),   64'd1);
        lit("rst_m_valid",   64'(m_valid),   64'd0);
        lit("rst_feat",      64'(feat),      64'd0);
        lit("rst_n_results", 64'(n_results), 64'd0);

        // Basic vector 41,00,00,00 with latency check.
        m_ready = 1'b1;
        send_vec(8'h41, k);
        wait_mvalid(e);
        lit("latency",     64'(e - k),     64'(SETTLE));
        lit("class_41",    64'(m_class),   MASK ? 64'd0 : 64'd1);
        lit("feat_x0_41",  64'(feat[7:0]), MASK ? 64'h40 : 64'h41);
        @(posedge clk); #1;
        lit("n_results_1", 64'(n_results), 64'd1);
        lit("s_ready_back", 64'(s_ready),  64'd1);

        // Early s_last aborts, then a full vector 03,...
        send_beat(8'h41, 1'b0, k);
        send_beat(8'h55, 1'b1, k);
        lit("frame_err_pulse", 64'(frame_err), 64'd1);
        @(posedge clk); #1;
        lit("frame_err_clear", 64'(frame_err), 64'd0);
        lit("no_abort_result", 64'(m_valid),   64'd0);
        send_vec(8'h03, k);
        wait_mvalid(e);
        lit("class_03",    64'(m_class),   MASK ? 64'd0 : 64'd3);
        @(posedge clk); #1;
        lit("n_results_2", 64'(n_results), 64'd2);

        // Back-pressure on the result port for 10 cycles.
        m_ready = 1'b0;
        send_vec(8'h02, k);
        wait_mvalid(e);
        saved = m_class;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            @(posedge clk); #1;
            if (m_valid && m_class == saved && !s_ready) ok++;
        end
        s_valid = 1'b0;
        lit("stall_stable", 64'(ok),      64'd10);
        lit("stall_class",  64'(m_class), MASK ? 64'd0 : 64'd2);
        lit("stall_feat",   64'(feat),    MASK ? 64'd0 : 64'h2);
        m_ready = 1'b1;
        @(posedge clk); #1;
        lit("stall_release_mv", 64'(m_valid),   64'd0);
        lit("n_results_3",      64'(n_results), 64'd3);

        // Reset while settling.
        m_ready = 1'b0;
        send_beat(8'h11, 1'b0, k);
        send_beat(8'h22, 1'b0, k);
        send_beat(8'h33, 1'b0, k);
        send_beat(8'h44, 1'b1, k);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lit("rst_mid_m_valid",   64'(m_valid),   64'd0);
        lit("rst_mid_feat",      64'(feat),      64'd0);
        lit("rst_mid_s_ready",   64'(s_ready),   64'd1);
        lit("rst_mid_n_results", 64'(n_results), 64'd0);

        // Counter wrap.
        force dut.n_results_q = 16'hFFFF;
        m_nres = 16'hFFFF;
        #1;
        release dut.n_results_q;
        lit("preload", 64'(n_results), 64'hFFFF);
        m_ready = 1'b1;
        send_vec(8'h01, k);
        wait_mvalid(e);
        @(posedge clk); #1;
        lit("wrap", 64'(n_results), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = 8'($urandom);
            s_last  = (m_pos == N_FEAT - 1) ? (($urandom % 10) != 0) : (($urandom % 20) == 0);
            m_ready = ($urandom % 2) != 0;
            rst_n   = ($urandom % 200) != 0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
